// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the requester-side handshake (req_valid/req_data/req_ready) and the
//   UART TX handshake (uart_tx_start/uart_tx_data/uart_tx_busy/uart_tx_clear_req)
//   seen by the UART TX arbiter.
//   slave  : the arbiter's view (consumes requests and UART status, drives
//            req_ready and the UART start/data lines)
//   master : the surrounding system's view (requesters plus the UART)
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      uart_tx_start;
  logic [DATA_W-1:0]         uart_tx_data;
  logic                      uart_tx_busy;
  logic                      uart_tx_clear_req;

  modport slave (
    input  req_valid, req_data, uart_tx_busy, uart_tx_clear_req,
    output req_ready, uart_tx_start, uart_tx_data
  );

  modport master (
    output req_valid, req_data, uart_tx_busy, uart_tx_clear_req,
    input  req_ready, uart_tx_start, uart_tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter among NUM_REQ requesters with round-robin
//   arbitration, one byte per grant. The granted byte is latched and offered
//   to the UART with a level start request; completion is taken from the
//   synchronised clear_req or a falling busy. Each wait state is bounded by
//   TIMEOUT cycles, after which the byte is dropped and timeout_err pulses.
// Ports
//   wb_clk_i      system clock
//   wb_rst_i      synchronous reset, active-high
//   bus           uart_tx_arbiter_if.slave (requests + UART handshake)
//   grant_id      index of the current or last granted requester
//   grant_active  high while a byte is in flight (state != IDLE)
//   timeout_err   one-cycle pulse when a byte is aborted
//   bytes_sent    count of completed bytes, wraps
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 2000000
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  uart_tx_arbiter_if.slave           bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_active,
  output logic                       timeout_err,
  output logic [15:0]                bytes_sent
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CW    = PTR_W + 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2} state_t;

  state_t              state_r, state_nxt_s;
  logic                busy_m_r, busy_s, busy_d_r, clr_m_r, clr_s;
  logic [PTR_W-1:0]    rr_ptr_r, rr_ptr_nxt_s;
  logic [TMR_W-1:0]    timer_r, timer_nxt_s;
  logic [NUM_REQ-1:0]  req_ready_r, req_ready_nxt_s;
  logic                start_r, start_nxt_s;
  logic [DATA_W-1:0]   data_r, data_nxt_s;
  logic [PTR_W-1:0]    grant_id_r, grant_id_nxt_s;
  logic                tmo_err_r, tmo_err_nxt_s;
  logic [15:0]         bytes_r, bytes_nxt_s;
  logic                any_req_s, done_s, tmo_s;
  logic [PTR_W-1:0]    grant_idx_s;
  logic [CW-1:0]       cand_s;

  assign bus.req_ready     = req_ready_r;
  assign bus.uart_tx_start = start_r;
  assign bus.uart_tx_data  = data_r;
  assign grant_id          = grant_id_r;
  assign grant_active      = (state_r != ST_IDLE);
  assign timeout_err       = tmo_err_r;
  assign bytes_sent        = bytes_r;

  // Two-flop synchronisers for the UART status, plus busy history for edge detect.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      busy_m_r <= 1'b0;
      busy_s   <= 1'b0;
      busy_d_r <= 1'b0;
      clr_m_r  <= 1'b0;
      clr_s    <= 1'b0;
    end else begin
      busy_m_r <= bus.uart_tx_busy;
      busy_s   <= busy_m_r;
      busy_d_r <= busy_s;
      clr_m_r  <= bus.uart_tx_clear_req;
      clr_s    <= clr_m_r;
    end
  end

  // Round-robin pick: scan offsets high to low so the smallest offset from rr_ptr wins.
  always_comb begin
    grant_idx_s = {PTR_W{1'b0}};
    cand_s      = {CW{1'b0}};
    any_req_s   = |bus.req_valid;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand_s      = {1'b0, rr_ptr_r} + CW'(i);
      cand_s      = (cand_s >= CW'(NUM_REQ)) ? (cand_s - CW'(NUM_REQ)) : cand_s;
      grant_idx_s = bus.req_valid[cand_s[PTR_W-1:0]] ? cand_s[PTR_W-1:0] : grant_idx_s;
    end
  end

  assign done_s = clr_s | (busy_d_r & ~busy_s);
  assign tmo_s  = (timer_r == TMO_LAST);

  // FSM state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; busy beats timeout in ISSUE, done beats timeout in WAIT.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) state_nxt_s = ST_ISSUE;
        else           state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (busy_s)     state_nxt_s = ST_WAIT;
        else if (tmo_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_ISSUE;
      end
      ST_WAIT: begin
        if (done_s)     state_nxt_s = ST_IDLE;
        else if (tmo_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_WAIT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs, timer and pointer.
  always_comb begin
    req_ready_nxt_s = {NUM_REQ{1'b0}};
    start_nxt_s     = start_r;
    data_nxt_s      = data_r;
    grant_id_nxt_s  = grant_id_r;
    tmo_err_nxt_s   = 1'b0;
    bytes_nxt_s     = bytes_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    timer_nxt_s     = timer_r + TMR_W'(1);
    case (state_r)
      ST_IDLE: begin
        timer_nxt_s = {TMR_W{1'b0}};
        if (any_req_s) begin
          data_nxt_s      = bus.req_data[grant_idx_s*DATA_W +: DATA_W];
          grant_id_nxt_s  = grant_idx_s;
          req_ready_nxt_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
          rr_ptr_nxt_s    = (grant_idx_s == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}}
                                                                 : grant_idx_s + PTR_W'(1);
          start_nxt_s     = 1'b1;
        end else begin
          start_nxt_s = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (busy_s) begin
          start_nxt_s = 1'b0;
          timer_nxt_s = {TMR_W{1'b0}};
        end else if (tmo_s) begin
          start_nxt_s   = 1'b0;
          tmo_err_nxt_s = 1'b1;
        end else begin
          start_nxt_s = 1'b1;
        end
      end
      ST_WAIT: begin
        if (done_s) begin
          bytes_nxt_s = bytes_r + 16'd1;
        end else if (tmo_s) begin
          tmo_err_nxt_s = 1'b1;
        end else begin
          start_nxt_s = 1'b0;
        end
      end
      default: begin
        start_nxt_s = 1'b0;
        timer_nxt_s = {TMR_W{1'b0}};
      end
    endcase
  end

  // Output and datapath registers; reset drops any in-flight byte.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      req_ready_r <= {NUM_REQ{1'b0}};
      start_r     <= 1'b0;
      data_r      <= {DATA_W{1'b0}};
      grant_id_r  <= {PTR_W{1'b0}};
      tmo_err_r   <= 1'b0;
      bytes_r     <= 16'd0;
      rr_ptr_r    <= {PTR_W{1'b0}};
      timer_r     <= {TMR_W{1'b0}};
    end else begin
      req_ready_r <= req_ready_nxt_s;
      start_r     <= start_nxt_s;
      data_r      <= data_nxt_s;
      grant_id_r  <= grant_id_nxt_s;
      tmo_err_r   <= tmo_err_nxt_s;
      bytes_r     <= bytes_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      timer_r     <= timer_nxt_s;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (NUM_REQ=4, DATA_W=8, TIMEOUT=16).
//   A frame table covers single-requester transfer, round-robin order and
//   wrap; hand-written sequences cover ISSUE/WAIT timeouts and mid-frame reset.
//   UART model modes: 0 busy then falling busy, 1 busy then clear pulse,
//   2 never busy, 3 busy stuck high until the mode changes.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant_id;
  logic       grant_active;
  logic       timeout_err;
  logic [15:0] bytes_sent;
  int         checks = 0;
  int         errors = 0;
  int         uart_mode = 0;

  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT(16)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .bus          (bus),
    .grant_id     (grant_id),
    .grant_active (grant_active),
    .timeout_err  (timeout_err),
    .bytes_sent   (bytes_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_rst;
    int          mode;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  exp_ready;
    logic [7:0]  exp_byte;
    logic [1:0]  exp_gid;
    logic [15:0] exp_bytes;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // UART model reacting to uart_tx_start
  initial begin
    bus.uart_tx_busy      = 1'b0;
    bus.uart_tx_clear_req = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.uart_tx_start && uart_mode != 2 && !bus.uart_tx_busy) begin
        repeat (2) @(negedge clk);
        bus.uart_tx_busy = 1'b1;
        repeat (4) @(negedge clk);
        if (uart_mode == 1) begin
          bus.uart_tx_clear_req = 1'b1;
          @(negedge clk);
          bus.uart_tx_clear_req = 1'b0;
          bus.uart_tx_busy      = 1'b0;
        end else if (uart_mode == 3) begin
          wait (uart_mode != 3);
          @(negedge clk);
          bus.uart_tx_busy = 1'b0;
        end else begin
          bus.uart_tx_busy = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready",  {28'd0, bus.req_ready}, 32'd0);
    check("rst_start",  {31'd0, bus.uart_tx_start}, 32'd0);
    check("rst_data",   {24'd0, bus.uart_tx_data}, 32'd0);
    check("rst_active", {31'd0, grant_active}, 32'd0);
    check("rst_gid",    {30'd0, grant_id}, 32'd0);
    check("rst_bytes",  {16'd0, bytes_sent}, 32'd0);
    rst = 1'b0;
  endtask

  // Present a request and check the accept cycle; leaves the bench at the negedge after it.
  task automatic grant_check(input logic [3:0] valid, input logic [31:0] data,
                             input logic [3:0] exp_ready, input logic [7:0] exp_byte,
                             input logic [1:0] exp_gid);
    int n;
    bus.req_valid = valid;
    bus.req_data  = data;
    n = 0;
    while (bus.req_ready == 4'd0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("grant_seen", {31'd0, (bus.req_ready != 4'd0)}, 32'd1);
    check("req_ready",  {28'd0, bus.req_ready}, {28'd0, exp_ready});
    check("tx_data",    {24'd0, bus.uart_tx_data}, {24'd0, exp_byte});
    check("tx_start",   {31'd0, bus.uart_tx_start}, 32'd1);
    check("grant_id",   {30'd0, grant_id}, {30'd0, exp_gid});
    check("active",     {31'd0, grant_active}, 32'd1);
    bus.req_valid = 4'd0;
    @(negedge clk);
    check("ready_pulse", {28'd0, bus.req_ready}, 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (grant_active && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("back_to_idle", {31'd0, grant_active}, 32'd0);
  endtask

  initial begin
    int n;
    bus.req_valid = 4'd0;
    bus.req_data  = 32'd0;
    vecs[0] = '{1'b1, 0, 4'b0001, 32'h0000_0041, 4'b0001, 8'h41, 2'd0, 16'd1};
    vecs[1] = '{1'b1, 1, 4'b1111, 32'h1312_1110, 4'b0001, 8'h10, 2'd0, 16'd1};
    vecs[2] = '{1'b0, 0, 4'b1111, 32'h1312_1110, 4'b0010, 8'h11, 2'd1, 16'd2};
    vecs[3] = '{1'b0, 1, 4'b1111, 32'h1312_1110, 4'b0100, 8'h12, 2'd2, 16'd3};
    vecs[4] = '{1'b0, 0, 4'b1111, 32'h1312_1110, 4'b1000, 8'h13, 2'd3, 16'd4};
    vecs[5] = '{1'b0, 0, 4'b1111, 32'h1312_1110, 4'b0001, 8'h10, 2'd0, 16'd5};
    vecs[6] = '{1'b0, 0, 4'b0010, 32'hA4A3_A2A1, 4'b0010, 8'hA2, 2'd1, 16'd6};
    vecs[7] = '{1'b0, 0, 4'b0011, 32'hA4A3_A2A1, 4'b0001, 8'hA1, 2'd0, 16'd7};
    vecs[8] = '{1'b0, 1, 4'b0011, 32'hA4A3_A2A1, 4'b0010, 8'hA2, 2'd1, 16'd8};

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_rst) do_reset();
      else @(negedge clk);
      uart_mode = vecs[i].mode;
      grant_check(vecs[i].valid, vecs[i].data, vecs[i].exp_ready, vecs[i].exp_byte, vecs[i].exp_gid);
      wait_idle();
      check("bytes_sent", {16'd0, bytes_sent}, {16'd0, vecs[i].exp_bytes});
      check("no_tmo_err", {31'd0, timeout_err}, 32'd0);
    end

    // ISSUE timeout: UART never answers, start holds 16 cycles (rr_ptr now 2)
    @(negedge clk);
    uart_mode = 2;
    grant_check(4'b0100, 32'h5453_5251, 4'b0100, 8'h53, 2'd2);
    n = 1;
    while (bus.uart_tx_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("issue_start_cycles", n, 32'd16);
    check("issue_tmo_pulse", {31'd0, timeout_err}, 32'd1);
    check("issue_tmo_idle", {31'd0, grant_active}, 32'd0);
    @(negedge clk);
    check("issue_tmo_one_cycle", {31'd0, timeout_err}, 32'd0);
    check("issue_tmo_bytes", {16'd0, bytes_sent}, 32'd8);
    uart_mode = 0;
    grant_check(4'b1000, 32'h5453_5251, 4'b1000, 8'h54, 2'd3);
    wait_idle();
    check("after_tmo_bytes", {16'd0, bytes_sent}, 32'd9);

    // WAIT_DONE timeout: busy rises and sticks
    @(negedge clk);
    uart_mode = 3;
    grant_check(4'b0001, 32'h0000_0077, 4'b0001, 8'h77, 2'd0);
    n = 0;
    while (bus.uart_tx_start && n < 60) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (grant_active && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_cycles", n, 32'd16);
    check("wait_tmo_pulse", {31'd0, timeout_err}, 32'd1);
    @(negedge clk);
    check("wait_tmo_one_cycle", {31'd0, timeout_err}, 32'd0);
    check("wait_tmo_bytes", {16'd0, bytes_sent}, 32'd9);
    uart_mode = 0;
    repeat (6) @(negedge clk);

    // Reset while in WAIT_DONE (grant 1 moves rr_ptr to 2 first)
    uart_mode = 3;
    grant_check(4'b0010, 32'h0000_6600, 4'b0010, 8'h66, 2'd1);
    n = 0;
    while (bus.uart_tx_start && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("in_wait", {31'd0, grant_active}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_start",  {31'd0, bus.uart_tx_start}, 32'd0);
    check("mid_rst_active", {31'd0, grant_active}, 32'd0);
    check("mid_rst_bytes",  {16'd0, bytes_sent}, 32'd0);
    check("mid_rst_data",   {24'd0, bus.uart_tx_data}, 32'd0);
    @(negedge clk);
    uart_mode = 0;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    grant_check(4'b1111, 32'hD3D2_D1D0, 4'b0001, 8'hD0, 2'd0);
    wait_idle();
    check("post_rst_bytes", {16'd0, bytes_sent}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
